// File: rtl/debounce_pkg.sv
// Shared constants, channel state type and counter-width helper for the debounce bank.
// Pure definitions: no logic, no latency, no flow control.
package debounce_pkg;

  localparam int DEF_DEBOUNCE_LIMIT = 2;
  localparam int DEF_SYNC_STAGES    = 2;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } ch_state_e;

  // Enough bits to hold 0..limit.
  function automatic int cnt_width(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/debounce_bank_if.sv
// Switch-bank bundle: raw inputs and tick toward the debouncer, clean levels and events back.
// Plain wires; no latency and no backpressure.
interface debounce_bank_if #(
  parameter int NUM_CH = 8
) ();

  logic [NUM_CH-1:0] raw_in;
  logic              sample_tick;
  logic [NUM_CH-1:0] stable_out;
  logic [NUM_CH-1:0] rise_pulse;
  logic [NUM_CH-1:0] fall_pulse;
  logic              any_change;
  logic [NUM_CH-1:0] long_press;

  modport master (
    output raw_in,
    output sample_tick,
    input  stable_out,
    input  rise_pulse,
    input  fall_pulse,
    input  any_change,
    input  long_press
  );

  modport slave (
    input  raw_in,
    input  sample_tick,
    output stable_out,
    output rise_pulse,
    output fall_pulse,
    output any_change,
    output long_press
  );

endinterface

// File: rtl/debounce_ch.sv
// One debounced channel: synchroniser, tick-qualified counter, edge pulses, long-press hold counter under DEBOUNCE_LONG_PRESS_EN.
// Level flips SYNC_STAGES+DEBOUNCE_LIMIT ticked edges after a held input change; no backpressure, pulses are single-cycle.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int   DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT,
  parameter int   SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter logic RESET_BIT      = 1'b0
`ifdef DEBOUNCE_LONG_PRESS_EN
  ,
  parameter int   LONG_LIMIT     = 1000
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  input  logic i_tick,
  output logic o_stable,
  output logic o_rise,
  output logic o_fall,
  output logic o_long
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_stable;
  logic                   r_rise;
  logic                   r_fall;

  logic                   w_s;
  ch_state_e              w_state;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   w_stable_nxt;
  logic                   w_rise_nxt;
  logic                   w_fall_nxt;

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync   <= {SYNC_STAGES{RESET_BIT}};
      r_cnt    <= '0;
      r_stable <= RESET_BIT;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], i_raw};
      r_cnt    <= w_cnt_nxt;
      r_stable <= w_stable_nxt;
      r_rise   <= w_rise_nxt;
      r_fall   <= w_fall_nxt;
    end
  end

  // The state is implied by the synchroniser disagreeing with the held level.
  always_comb begin
    w_state      = (w_s == r_stable) ? ST_STABLE : ST_COUNTING;
    w_cnt_nxt    = '0;
    w_stable_nxt = r_stable;
    w_rise_nxt   = 1'b0;
    w_fall_nxt   = 1'b0;
    case (w_state)
      ST_COUNTING: begin
        if (!i_tick) begin
          w_cnt_nxt = r_cnt;
        end else if (r_cnt == CNT_LAST) begin
          w_stable_nxt = w_s;
          w_rise_nxt   = w_s;
          w_fall_nxt   = !w_s;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  assign o_stable = r_stable;
  assign o_rise   = r_rise;
  assign o_fall   = r_fall;

`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam int                HOLD_W    = cnt_width(LONG_LIMIT);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_LIMIT - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_LIMIT);

  logic [HOLD_W-1:0] r_hold;
  logic              r_long;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic              w_long_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hold <= '0;
      r_long <= 1'b0;
    end else begin
      r_hold <= w_hold_nxt;
      r_long <= w_long_nxt;
    end
  end

  // Saturating at LONG_LIMIT parks the channel until the level drops and re-arms it.
  always_comb begin
    w_hold_nxt = r_hold;
    w_long_nxt = 1'b0;
    if (!r_stable) begin
      w_hold_nxt = '0;
    end else if (i_tick) begin
      if (r_hold == HOLD_LAST) begin
        w_hold_nxt = HOLD_SAT;
        w_long_nxt = 1'b1;
      end else if (r_hold != HOLD_SAT) begin
        w_hold_nxt = r_hold + 1'b1;
      end
    end
  end

  assign o_long = r_long;
`else
  assign o_long = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// NUM_CH independent debounced switch channels with rise/fall/any-change events; long_press live only with DEBOUNCE_LONG_PRESS_EN.
// Latency SYNC_STAGES+DEBOUNCE_LIMIT ticked edges from a held input change; no backpressure.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int              NUM_CH         = 8,
  parameter int              DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT,
  parameter int              SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter logic [NUM_CH-1:0] RESET_VAL    = '0,
  parameter int              LONG_LIMIT     = 1000
) (
  input  logic             clk,
  input  logic             reset,
  debounce_bank_if.slave   bus
);

  logic [NUM_CH-1:0] w_stable;
  logic [NUM_CH-1:0] w_rise;
  logic [NUM_CH-1:0] w_fall;
  logic [NUM_CH-1:0] w_long;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    debounce_ch #(
      .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
      .SYNC_STAGES    (SYNC_STAGES),
      .RESET_BIT      (RESET_VAL[gi])
`ifdef DEBOUNCE_LONG_PRESS_EN
      ,
      .LONG_LIMIT     (LONG_LIMIT)
`endif
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .i_raw    (bus.raw_in[gi]),
      .i_tick   (bus.sample_tick),
      .o_stable (w_stable[gi]),
      .o_rise   (w_rise[gi]),
      .o_fall   (w_fall[gi]),
      .o_long   (w_long[gi])
    );
  end

  assign bus.stable_out = w_stable;
  assign bus.rise_pulse = w_rise;
  assign bus.fall_pulse = w_fall;
  assign bus.any_change = |(w_rise | w_fall);
  // A non-positive hold limit means long-press reporting is off.
  assign bus.long_press = w_long & {NUM_CH{LONG_LIMIT > 0}};

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank across four parameter sets; long-press steps follow DEBOUNCE_LONG_PRESS_EN.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_debounce_bank;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  debounce_bank_if #(.NUM_CH(8)) if0 ();
  debounce_bank_if #(.NUM_CH(8)) if1 ();
  debounce_bank_if #(.NUM_CH(8)) if2 ();
  debounce_bank_if #(.NUM_CH(2)) if3 ();

  debounce_bank #(.NUM_CH(8), .LONG_LIMIT(5)) u0 (.clk(clk), .reset(reset), .bus(if0));
  debounce_bank #(.NUM_CH(8), .DEBOUNCE_LIMIT(4)) u1 (.clk(clk), .reset(reset), .bus(if1));
  debounce_bank #(.NUM_CH(8), .DEBOUNCE_LIMIT(3), .RESET_VAL(8'hFF)) u2 (.clk(clk), .reset(reset), .bus(if2));
  debounce_bank #(.NUM_CH(2), .DEBOUNCE_LIMIT(1), .SYNC_STAGES(3)) u3 (.clk(clk), .reset(reset), .bus(if3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    if0.raw_in = 8'h00; if0.sample_tick = 1'b1;
    if1.raw_in = 8'h00; if1.sample_tick = 1'b1;
    if2.raw_in = 8'hFF; if2.sample_tick = 1'b0;
    if3.raw_in = 2'b00; if3.sample_tick = 1'b1;
    #2 reset = 1'b0;
    cyc(3);
    chk("rst_u0_stable", if0.stable_out, 32'h00);
    chk("rst_u0_rise",   if0.rise_pulse, 32'h00);
    chk("rst_u0_fall",   if0.fall_pulse, 32'h00);
    chk("rst_u0_any",    if0.any_change, 32'h0);
    chk("rst_u0_long",   if0.long_press, 32'h00);
    chk("rst_u2_stable", if2.stable_out, 32'hFF);
    chk("rst_u3_stable", if3.stable_out, 32'h0);
    reset = 1'b1;

    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("release_u2_any", if2.any_change, 32'h0);
    end
    chk("release_u2_stable", if2.stable_out, 32'hFF);

    // Single rise on channel 0: flip lands on edge 4.
    if0.raw_in = 8'h01;
    cyc(3);
    chk("rise_e3_stable", if0.stable_out, 32'h00);
    cyc(1);
    chk("rise_e4_stable", if0.stable_out, 32'h01);
    chk("rise_e4_rise",   if0.rise_pulse, 32'h01);
    chk("rise_e4_fall",   if0.fall_pulse, 32'h00);
    chk("rise_e4_any",    if0.any_change, 32'h1);
    cyc(1);
    chk("rise_e5_rise",   if0.rise_pulse, 32'h00);
    chk("rise_e5_any",    if0.any_change, 32'h0);
    chk("rise_e5_stable", if0.stable_out, 32'h01);

    if0.raw_in = 8'h00;
    cyc(3);
    chk("fall_e3_stable", if0.stable_out, 32'h01);
    cyc(1);
    chk("fall_e4_stable", if0.stable_out, 32'h00);
    chk("fall_e4_fall",   if0.fall_pulse, 32'h01);
    chk("fall_e4_rise",   if0.rise_pulse, 32'h00);
    cyc(1);
    chk("fall_e5_fall",   if0.fall_pulse, 32'h00);

    // Several channels flipping on the same edge.
    if0.raw_in = 8'hA5;
    cyc(3);
    chk("multi_e3_stable", if0.stable_out, 32'h00);
    cyc(1);
    chk("multi_e4_stable", if0.stable_out, 32'hA5);
    chk("multi_e4_rise",   if0.rise_pulse, 32'hA5);
    chk("multi_e4_fall",   if0.fall_pulse, 32'h00);
    chk("multi_e4_any",    if0.any_change, 32'h1);
    cyc(1);
    chk("multi_e5_rise",   if0.rise_pulse, 32'h00);
    chk("multi_e5_any",    if0.any_change, 32'h0);
    if0.raw_in = 8'h00;
    cyc(6);
    chk("multi_settle_stable", if0.stable_out, 32'h00);

    // Limit 4: a 3-cycle glitch is one tick short of flipping.
    if1.raw_in = 8'h08;
    cyc(3);
    if1.raw_in = 8'h00;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      chk("glitch_stable", if1.stable_out, 32'h00);
      chk("glitch_any",    if1.any_change, 32'h0);
    end
    chk("glitch_cnt", u1.g_ch[3].u_ch.r_cnt, 32'h0);
    if1.raw_in = 8'h08;
    cyc(5);
    chk("lim4_e5_stable", if1.stable_out, 32'h00);
    cyc(1);
    chk("lim4_e6_stable", if1.stable_out, 32'h08);
    chk("lim4_e6_rise",   if1.rise_pulse, 32'h08);

    // Limit 1, three sync stages: flip on edge 4; tick low freezes counting.
    if3.raw_in = 2'b11;
    cyc(3);
    chk("lim1_e3_stable", if3.stable_out, 32'h0);
    cyc(1);
    chk("lim1_e4_stable", if3.stable_out, 32'h3);
    chk("lim1_e4_rise",   if3.rise_pulse, 32'h3);
    if3.raw_in = 2'b00;
    if3.sample_tick = 1'b0;
    cyc(8);
    chk("lim1_notick_stable", if3.stable_out, 32'h3);
    chk("lim1_notick_fall",   if3.fall_pulse, 32'h0);
    if3.sample_tick = 1'b1;
    cyc(1);
    chk("lim1_tick_stable", if3.stable_out, 32'h0);
    chk("lim1_tick_fall",   if3.fall_pulse, 32'h3);

    // Limit 3, tick on every 4th edge: ticks at edges 4, 8, 12; flip at 12.
    for (int c = 1; c <= 13; c++) begin
      if2.sample_tick = (c % 4 == 0);
      if (c == 1) if2.raw_in = 8'hFD;
      cyc(1);
      if (c == 11) chk("slow_e11_stable", if2.stable_out, 32'hFF);
      if (c == 12) begin
        chk("slow_e12_stable", if2.stable_out, 32'hFD);
        chk("slow_e12_fall",   if2.fall_pulse, 32'h02);
        chk("slow_e12_rise",   if2.rise_pulse, 32'h00);
        chk("slow_e12_any",    if2.any_change, 32'h1);
      end
      if (c == 13) begin
        chk("slow_e13_fall",   if2.fall_pulse, 32'h00);
        chk("slow_e13_stable", if2.stable_out, 32'hFD);
      end
    end

    // Reset in the middle of a count, then a fresh count from zero.
    if2.sample_tick = 1'b1;
    if2.raw_in = 8'hFF;
    cyc(4);
    chk("midrst_pre_stable", if2.stable_out, 32'hFD);
    reset = 1'b0;
    #1;
    chk("midrst_stable", if2.stable_out, 32'hFF);
    chk("midrst_rise",   if2.rise_pulse, 32'h00);
    chk("midrst_fall",   if2.fall_pulse, 32'h00);
    chk("midrst_any",    if2.any_change, 32'h0);
    chk("midrst_cnt",    u2.g_ch[1].u_ch.r_cnt, 32'h0);
    cyc(2);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      chk("midrst_release_any", if2.any_change, 32'h0);
    end
    if2.raw_in = 8'hFD;
    cyc(4);
    chk("restart_e4_stable", if2.stable_out, 32'hFF);
    cyc(1);
    chk("restart_e5_stable", if2.stable_out, 32'hFD);
    chk("restart_e5_fall",   if2.fall_pulse, 32'h02);

`ifdef DEBOUNCE_LONG_PRESS_EN
    // LONG_LIMIT 5: level rises at edge 4, long_press at edge 9.
    if0.raw_in = 8'h01;
    cyc(4);
    chk("long_e4_stable", if0.stable_out, 32'h01);
    cyc(4);
    chk("long_e8", if0.long_press, 32'h00);
    cyc(1);
    chk("long_e9", if0.long_press, 32'h01);
    cyc(1);
    chk("long_e10", if0.long_press, 32'h00);
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("long_hold_norepeat", if0.long_press, 32'h00);
    end
    if0.raw_in = 8'h00;
    cyc(4);
    chk("long_release_fall", if0.fall_pulse, 32'h01);
    cyc(2);
    if0.raw_in = 8'h01;
    cyc(8);
    chk("long2_e8", if0.long_press, 32'h00);
    cyc(1);
    chk("long2_e9", if0.long_press, 32'h01);
    cyc(1);
    chk("long2_e10", if0.long_press, 32'h00);
`else
    if0.raw_in = 8'h01;
    for (int i = 0; i < 15; i++) begin
      cyc(1);
      chk("long_off", if0.long_press, 32'h00);
    end
    chk("long_off_stable", if0.stable_out, 32'h01);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
